fetch_align: RTL and testbench

- Instruction fetch and alignment stage directly upstream of the RV32IMAC decoder; drives the decoder's 32-bit instruction input.
- Issues word-aligned fetch requests and buffers returned words as halfwords.
- Re-aligns 16-bit (C) and 32-bit instructions, including 32-bit instructions straddling a word boundary, and presents one instruction per handshake with its PC.
- Handles PC redirects (branch/jump/trap) by flushing the buffer and dropping stale in-flight responses.

---
 rtl/fetch_align_if.sv | 36 +++
 rtl/fetch_align.sv | 147 ++++++++++++++
 tb/tb_fetch_align.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_if.sv
// ---------------------------------------------------------------------------
// fetch_align_if
//   Bundles every bus-level signal of the fetch/align stage into one interface.
//   Signal suffixes are written from the point of view of fetch_align.
//
//   Fetch side : fch_req_o, fch_addr_o, fch_ack_i, fch_rvalid_i, fch_rdata_i
//   Redirect   : redir_i, redir_pc_i
//   Decode side: inst_valid_o, inst_o, inst_pc_o, inst_com_o, inst_ready_i
//
//   master : the fetch_align view (drives requests and instructions)
//   slave  : the environment view (memory, branch unit, decoder)
// ---------------------------------------------------------------------------
interface fetch_align_if;
    logic        fch_req_o;
    logic [31:0] fch_addr_o;
    logic        fch_ack_i;
    logic        fch_rvalid_i;
    logic [31:0] fch_rdata_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_com_o;
    logic        inst_ready_i;

    modport master (
        output fch_req_o, fch_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_com_o,
        input  fch_ack_i, fch_rvalid_i, fch_rdata_i, redir_i, redir_pc_i, inst_ready_i
    );

    modport slave (
        input  fch_req_o, fch_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_com_o,
        output fch_ack_i, fch_rvalid_i, fch_rdata_i, redir_i, redir_pc_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_align.sv
// ---------------------------------------------------------------------------
// fetch_align
//   Instruction fetch and alignment stage in front of the RV32IMAC decoder.
//   Issues word-aligned fetch requests, stores returned words as halfwords,
//   and hands the decoder one 16-bit or 32-bit instruction per handshake,
//   including 32-bit instructions that straddle a word boundary.
//
//   Ports:
//     clk_i  - clock, all state on the rising edge
//     rst_i  - synchronous active-low reset
//     bus    - fetch_align_if.master (fetch bus, redirect, decoder handshake)
//
//   The halfword buffer is a flat shift register: entry 0 (bits [15:0]) is
//   always the oldest halfword and every position at or above the fill count
//   holds zero, so appends can simply be OR-ed in at the fill position.
// ---------------------------------------------------------------------------
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 6,
    parameter int          MAX_OUT  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_align_if.master bus
);
    localparam int BUFW = 16 * BUF_HW;
    localparam int CW   = $clog2(BUF_HW + 1);

    logic [BUFW-1:0] buf_q, buf_d;
    logic [CW-1:0]   hwCnt_q, hwCnt_d;
    logic [1:0]      outCnt_q, outCnt_d;
    logic [1:0]      drop_q, drop_d;
    logic            skip_q, skip_d;
    logic            run_q;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     pc_q, pc_d;

    logic [15:0] hw0, hw1;
    logic        isCom, instValid, consume, reqValid, ackFire;
    logic [31:0] appendData;
    int          popN, appendN, baseIdx, spaceNeed;

    assign hw0 = buf_q[15:0];
    assign hw1 = buf_q[31:16];

    // Anything whose two low bits are not 11 is a compressed instruction;
    // longer encodings are simply treated as 32-bit.
    assign isCom     = (hw0[1:0] != 2'b11);
    assign instValid = isCom ? (hwCnt_q != '0) : (int'(hwCnt_q) >= 2);
    assign consume   = instValid && bus.inst_ready_i;
    assign ackFire   = reqValid && bus.fch_ack_i;

    assign bus.inst_valid_o = instValid;
    assign bus.inst_o       = isCom ? {16'h0000, hw0} : {hw1, hw0};
    assign bus.inst_pc_o    = pc_q;
    assign bus.inst_com_o   = isCom && (hwCnt_q != '0);
    assign bus.fch_req_o    = reqValid;
    assign bus.fch_addr_o   = addr_q;

    // Only request when the live (non-dropped) in-flight words plus the
    // current fill still leave room for one more word in the buffer.
    always_comb begin
        spaceNeed = int'(hwCnt_q) + 2 * (int'(outCnt_q) - int'(drop_q)) + 2;
        reqValid  = run_q && (int'(outCnt_q) < MAX_OUT) && (spaceNeed <= BUF_HW);
    end

    // Next-state logic: a redirect wins over consume and response; the
    // outstanding count after this cycle becomes the number of words to drop.
    always_comb begin
        buf_d      = buf_q;
        hwCnt_d    = hwCnt_q;
        drop_d     = drop_q;
        skip_d     = skip_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        popN       = 0;
        appendN    = 0;
        appendData = '0;
        baseIdx    = 0;
        outCnt_d   = outCnt_q + {1'b0, ackFire} - {1'b0, bus.fch_rvalid_i};

        if (bus.redir_i) begin
            buf_d   = '0;
            hwCnt_d = '0;
            pc_d    = bus.redir_pc_i & ~32'd1;
            addr_d  = bus.redir_pc_i & ~32'd3;
            skip_d  = bus.redir_pc_i[1];
            drop_d  = outCnt_d;
        end else begin
            if (ackFire) begin
                addr_d = addr_q + 32'd4;
            end
            if (consume) begin
                popN = isCom ? 1 : 2;
                pc_d = pc_q + (isCom ? 32'd2 : 32'd4);
            end
            if (bus.fch_rvalid_i) begin
                if (drop_q != 2'd0) begin
                    drop_d = drop_q - 2'd1;
                end else if (skip_q) begin
                    appendN    = 1;
                    appendData = {16'h0000, bus.fch_rdata_i[31:16]};
                    skip_d     = 1'b0;
                end else begin
                    appendN    = 2;
                    appendData = bus.fch_rdata_i;
                end
            end
            baseIdx = int'(hwCnt_q) - popN;
            buf_d   = (buf_q >> (16 * popN)) | (BUFW'(appendData) << (16 * baseIdx));
            hwCnt_d = CW'(baseIdx + appendN);
        end
    end

    // State register; run_q holds off the first request until the cycle
    // after reset is released.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_q    <= '0;
            hwCnt_q  <= '0;
            outCnt_q <= '0;
            drop_q   <= '0;
            skip_q   <= 1'b0;
            run_q    <= 1'b0;
            addr_q   <= RESET_PC & ~32'd3;
            pc_q     <= RESET_PC;
        end else begin
            buf_q    <= buf_d;
            hwCnt_q  <= hwCnt_d;
            outCnt_q <= outCnt_d;
            drop_q   <= drop_d;
            skip_q   <= skip_d;
            run_q    <= 1'b1;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
        end
    end

    // Structural invariants of the counters and buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            assert (int'(outCnt_q) <= MAX_OUT);
            assert (drop_q <= outCnt_q);
            assert (int'(hwCnt_q) <= BUF_HW);
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// ---------------------------------------------------------------------------
// tb_fetch_align
//   Directed bench for fetch_align: a small in-order memory responder with
//   programmable latency, plus a linear sequence of directed steps whose
//   expected instruction words and PCs are written out by hand.
// ---------------------------------------------------------------------------
module tb_fetch_align;
    logic clk;
    logic rstN;

    fetch_align_if ifc ();

    fetch_align #(
        .RESET_PC (32'h0000_0000),
        .BUF_HW   (6),
        .MAX_OUT  (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rstN),
        .bus   (ifc.master)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pendQ[$];
    logic [31:0] mem [0:511];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory request side: record accepted requests with their due cycle and
    // retire the head whenever a response is presented.
    always @(posedge clk) begin
        pend_t entry;
        if (ifc.fch_rvalid_i === 1'b1 && pendQ.size() > 0) begin
            void'(pendQ.pop_front());
        end
        if (!rstN) begin
            pendQ.delete();
        end else if (ifc.fch_req_o && ifc.fch_ack_i) begin
            entry.addr = ifc.fch_addr_o;
            entry.due  = 32'(cyc + lat);
            pendQ.push_back(entry);
        end
        cyc++;
    end

    // Memory response side: drive the head response once its due cycle is
    // the upcoming rising edge.
    always @(negedge clk) begin
        logic [31:0] a;
        if (pendQ.size() > 0 && int'(pendQ[0].due) <= cyc) begin
            a                = pendQ[0].addr;
            ifc.fch_rvalid_i = 1'b1;
            ifc.fch_rdata_i  = mem[a[10:2]];
        end else begin
            ifc.fch_rvalid_i = 1'b0;
            ifc.fch_rdata_i  = 32'h0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive decoder-ready and redirect for one rising edge, then drop redirect.
    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] redirPc);
        ifc.inst_ready_i = ready;
        ifc.redir_i      = redir;
        ifc.redir_pc_i   = redirPc;
        @(negedge clk);
        ifc.redir_i = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (ifc.inst_valid_o !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, ifc.inst_valid_o}, 32'd1);
    endtask

    // Stop accepting requests, let in-flight responses drain, then hold
    // reset low across exactly one rising edge.
    task automatic quiesceAndReset();
        int n;
        ifc.fch_ack_i = 1'b0;
        n = 0;
        while (pendQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(pendQ.size()), 32'd0);
        rstN = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"},   {31'b0, ifc.fch_req_o},    32'd0);
        checkOutput({tag, "_valid"}, {31'b0, ifc.inst_valid_o}, 32'd0);
        checkOutput({tag, "_addr"},  ifc.fch_addr_o,            32'h0);
        checkOutput({tag, "_pc"},    ifc.inst_pc_o,             32'h0);
        checkOutput({tag, "_com"},   {31'b0, ifc.inst_com_o},   32'd0);
        checkOutput({tag, "_inst"},  ifc.inst_o,                32'h0);
    endtask

    task automatic checkInst(input string tag, input logic [31:0] inst,
                             input logic [31:0] pc, input logic com);
        checkOutput({tag, "_valid"}, {31'b0, ifc.inst_valid_o}, 32'd1);
        checkOutput({tag, "_inst"},  ifc.inst_o,                inst);
        checkOutput({tag, "_pc"},    ifc.inst_pc_o,             pc);
        checkOutput({tag, "_com"},   {31'b0, ifc.inst_com_o},   {31'b0, com});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        rstN             = 1'b0;
        ifc.fch_ack_i    = 1'b1;
        ifc.redir_i      = 1'b0;
        ifc.redir_pc_i   = 32'h0;
        ifc.inst_ready_i = 1'b0;
        lat              = 1;

        // Reset state
        repeat (2) @(negedge clk);
        checkResetState("rst");

        // Two aligned 32-bit instructions, 1-cycle memory
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        ifc.inst_ready_i = 1'b1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("t1_req0",  {31'b0, ifc.fch_req_o}, 32'd1);
        checkOutput("t1_addr0", ifc.fch_addr_o, 32'h0);
        @(negedge clk);
        checkOutput("t1_addr1",  ifc.fch_addr_o, 32'h4);
        checkOutput("t1_nvalid", {31'b0, ifc.inst_valid_o}, 32'd0);
        @(negedge clk);
        checkInst("t1_i0", 32'h0050_0093, 32'h0, 1'b0);
        @(negedge clk);
        checkInst("t1_i1", 32'h00A0_0113, 32'h4, 1'b0);

        // Compressed, then a straddling 32-bit, then compressed
        quiesceAndReset();
        checkResetState("t2rst");
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h4505_0050;
        ifc.fch_ack_i = 1'b1;
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkInst("t2_i0", 32'h0000_4501, 32'h0, 1'b1);
        @(negedge clk);
        checkInst("t2_i1", 32'h0050_0093, 32'h2, 1'b0);
        @(negedge clk);
        checkInst("t2_i2", 32'h0000_4505, 32'h6, 1'b1);

        // Redirect to a halfword-offset target
        mem[32'h100 >> 2] = 32'h0000_4505;
        mem[32'h104 >> 2] = 32'h0000_0001;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h0000_0102);
        checkOutput("t3_nvalid", {31'b0, ifc.inst_valid_o}, 32'd0);
        checkOutput("t3_pc",     ifc.inst_pc_o,  32'h102);
        checkOutput("t3_addr",   ifc.fch_addr_o, 32'h100);
        waitValid("t3_wait0", 20);
        checkInst("t3_i0", 32'h0000_0000, 32'h102, 1'b1);
        @(negedge clk);
        waitValid("t3_wait1", 20);
        checkInst("t3_i1", 32'h0000_0001, 32'h104, 1'b1);

        // Long latency, two stale requests in flight at redirect
        mem[32'h200 >> 2] = 32'h00A0_0113;
        lat = 4;
        n = 0;
        while (pendQ.size() != 2 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_inflight", 32'(pendQ.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        checkOutput("t4_nvalid", {31'b0, ifc.inst_valid_o}, 32'd0);
        checkOutput("t4_pc",     ifc.inst_pc_o,  32'h200);
        checkOutput("t4_addr",   ifc.fch_addr_o, 32'h200);
        waitValid("t4_wait", 30);
        checkInst("t4_i0", 32'h00A0_0113, 32'h200, 1'b0);

        // Back-to-back redirects: the second target wins
        mem[32'h208 >> 2] = 32'h0000_4509;
        lat = 2;
        repeat (4) @(negedge clk);
        ifc.redir_i    = 1'b1;
        ifc.redir_pc_i = 32'h0000_0300;
        @(negedge clk);
        ifc.redir_pc_i = 32'h0000_0208;
        @(negedge clk);
        ifc.redir_i = 1'b0;
        checkOutput("t4b_pc",   ifc.inst_pc_o,  32'h208);
        checkOutput("t4b_addr", ifc.fch_addr_o, 32'h208);
        waitValid("t4b_wait", 30);
        checkInst("t4b_i0", 32'h0000_4509, 32'h208, 1'b1);

        // Decoder stalls: buffer fills, requests stop, output holds
        mem[32'h400 >> 2] = 32'h00C0_0193;
        mem[32'h404 >> 2] = 32'h4505_4501;
        mem[32'h408 >> 2] = 32'h0000_4509;
        lat = 1;
        applyStimulus(1'b0, 1'b1, 32'h0000_0400);
        repeat (9) @(negedge clk);
        checkInst("t5_hold10", 32'h00C0_0193, 32'h400, 1'b0);
        repeat (10) @(negedge clk);
        checkInst("t5_hold20", 32'h00C0_0193, 32'h400, 1'b0);
        checkOutput("t5_noreq", {31'b0, ifc.fch_req_o}, 32'd0);
        checkOutput("t5_addr",  ifc.fch_addr_o, 32'h40C);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkInst("t5_i1", 32'h0000_4501, 32'h404, 1'b1);
        checkOutput("t5_resume", {31'b0, ifc.fch_req_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkInst("t5_i2", 32'h0000_4505, 32'h406, 1'b1);

        // Reset mid-stream restarts fetch from the reset PC
        quiesceAndReset();
        checkResetState("t6rst");
        ifc.fch_ack_i = 1'b1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("t6_req",  {31'b0, ifc.fch_req_o}, 32'd1);
        checkOutput("t6_addr", ifc.fch_addr_o, 32'h0);
        repeat (2) @(negedge clk);
        checkInst("t6_i0", 32'h0000_4501, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
